ptm_match_collector: RTL
========================

Name: ptm_match_collector

Overview:
- Downstream consumer of the pattern-matching engine's probe bus (en/addr/flag/fin/result).
- Captures the address of every flagged probe into a small FIFO and keeps a running match count.
- Streams the captured addresses out over a valid/ready port and reports completion once the engine signals fin.
- Sits between the PTM block and the host/readout logic.

Parameters:
- MEM_WIDTH, 10, width of the probe address and of the match count.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  same start pulse/level fed to PTM; arms collection.
- en  input  1  PTM probe strobe.
- addr  input  MEM_WIDTH  PTM probe address.
- flag  input  1  PTM match flag for the current addr; qualified by en.
- fin  input  1  PTM finished.
- result  input  MEM_WIDTH  PTM final match count; valid while fin=1.
- out_valid  output  1  out_addr holds a captured match address.
- out_ready  input  1  consumer accepts out_addr when out_valid & out_ready.
- out_addr  output  MEM_WIDTH  head-of-FIFO match address.
- count  output  MEM_WIDTH  matches seen since start; saturates at 2^MEM_WIDTH-1.
- overflow  output  1  sticky: at least one match was dropped because the FIFO was full.
- done  output  1  fin seen and FIFO fully drained.
- mismatch  output  1  count differs from result at fin (optional feature).

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO empty; all outputs 0 (out_valid=0, out_addr=0, count=0, overflow=0, done=0, mismatch=0). Reset mid-operation discards all FIFO contents and the count immediately.
- States:
  - IDLE: start=1 -> COLLECT; count, overflow, mismatch and the FIFO are cleared on entry.
  - COLLECT:
    - Each rising edge with en=1 & flag=1 is one match: count+1 (saturating) and addr pushed to the FIFO.
    - en=1 with flag=0 is ignored. en=0 ignores flag and addr.
    - Repeated addresses are each counted; no de-duplication.
    - fin=1 -> DRAIN. A match sampled in the same edge as fin is still counted and pushed.
  - DRAIN: no further captures; stays here until the FIFO is empty, then -> DONE.
  - DONE: done=1. Stays until start is seen low then high again, which starts a new collection -> COLLECT with clearing as above. Otherwise holds.
- FIFO:
  - Registered pointers with an extra wrap bit.
  - full and empty derived from pointer comparison.
  - out_valid = !empty; out_addr = mem[rd_ptr] (combinational read of the registered array).
  - Pop on out_valid & out_ready. Popping is allowed in COLLECT and DRAIN.
  - Push and pop in the same cycle: both take effect, including when full. A push into a full FIFO is accepted only if a pop happens in the same cycle; otherwise the push is dropped and overflow is set to 1, sticky until the next start or rst.
  - Pointers wrap modulo DEPTH.
- Latency: a match sampled at edge N gives out_valid=1 after edge N, provided the FIFO was empty.
- count is updated with the edge that samples the match; the saturation rule applies only when count is already at its maximum.
- done deasserts on re-arm. out_valid is never 1 in IDLE.

Optional Feature:
- Macro: PTM_COLLECT_CHECK_EN.
- Defined:
  - On the edge that samples fin=1 in COLLECT, compare count (including any same-edge match) against result.
  - mismatch is registered to 1 if they differ, or if overflow=1 and count is saturated.
  - mismatch holds until re-arm or rst.
- Undefined: mismatch is tied to 0 and no comparator is synthesised. result is unused.

Test Plan:
- Reset/idle: assert rst mid-collection with 5 entries queued -> next cycle out_valid=0, count=0, done=0, overflow=0.
- Basic capture: start, then probes at addr 3, 7, 7, 900 with flag=1 and others with flag=0; hold out_ready=1; fin with result=4 -> out_addr stream 3, 7, 7, 900; count=4; done=1; mismatch=0.
- Backpressure/overflow: out_ready=0, DEPTH=16, 18 flagged probes -> 16 entries stored, overflow=1, count=18; then release out_ready -> exactly 16 pops, then done.
- Full with simultaneous push/pop: FIFO full, out_ready=1, flagged probe the same cycle -> no drop, overflow stays 0, occupancy stays 16.
- Fin edge: flagged probe at addr 1023 sampled on the same edge as fin -> counted and streamed; no capture after fin even with en=1 & flag=1.
- Check feature (macro defined): 2 matches, fin with result=3 -> mismatch=1. Macro undefined -> mismatch=0.

Source files
------------

// File: rtl/ptm_match_if.sv
// ---------------------------------------------------------------------------
// ptm_match_if
//   Bundles the signals between the pattern-matching engine and the match
//   collector, together with the collector's readout port.
//
//   Probe side (engine -> collector):
//     start   arms a new collection (same pulse/level the engine receives)
//     en      probe strobe
//     addr    probe address
//     flag    match flag for addr, qualified by en
//     fin     engine finished
//     result  engine's final match count, valid while fin=1
//   Readout side (collector <-> host):
//     out_valid / out_ready / out_addr   captured-address stream
//     count     matches seen since start (saturating)
//     overflow  sticky: a match was dropped because the FIFO was full
//     done      fin seen and FIFO drained
//     mismatch  count disagreed with result at fin (optional check)
//
//   Modports: master = engine + host side, slave = collector.
// ---------------------------------------------------------------------------
interface ptm_match_if #(
    parameter int MEM_WIDTH = 10
);
    logic                 start;
    logic                 en;
    logic [MEM_WIDTH-1:0] addr;
    logic                 flag;
    logic                 fin;
    logic [MEM_WIDTH-1:0] result;
    logic                 out_valid;
    logic                 out_ready;
    logic [MEM_WIDTH-1:0] out_addr;
    logic [MEM_WIDTH-1:0] count;
    logic                 overflow;
    logic                 done;
    logic                 mismatch;

    modport master (
        output start, en, addr, flag, fin, result, out_ready,
        input  out_valid, out_addr, count, overflow, done, mismatch
    );

    modport slave (
        input  start, en, addr, flag, fin, result, out_ready,
        output out_valid, out_addr, count, overflow, done, mismatch
    );
endinterface

// File: rtl/ptm_match_collector.sv
// ---------------------------------------------------------------------------
// ptm_match_collector
//   Watches the pattern-matching engine's probe bus, captures the address of
//   every flagged probe into a DEPTH-entry FIFO, keeps a saturating match
//   count, streams the captured addresses out over valid/ready and raises
//   done once the engine has finished and the FIFO is drained.
//
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous, active-high reset
//     bus  ptm_match_if.slave (probe inputs, readout stream, status)
//
//   Parameters:
//     MEM_WIDTH  probe address / count width
//     DEPTH      FIFO entries (power of two, >= 2)
//     PTR_W      log2(DEPTH)
//
//   Optional build macro PTM_COLLECT_CHECK_EN: when defined, the count is
//   compared with the engine's result on the fin edge and a sticky mismatch
//   flag is kept. When undefined, mismatch is tied low and result is unused.
// ---------------------------------------------------------------------------
module ptm_match_collector #(
    parameter int MEM_WIDTH = 10,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    ptm_match_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [MEM_WIDTH-1:0] COUNT_MAX = '1;

    state_t               state_q, state_d;
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [MEM_WIDTH-1:0] mem_q [DEPTH];
    logic [MEM_WIDTH-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 seen_low_q, seen_low_d;

    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 match;
    logic                 push;
    logic                 drop;
    logic                 arm;
    logic [MEM_WIDTH-1:0] count_upd;
    logic                 overflow_upd;

    // The extra wrap bit distinguishes full from empty when the index bits
    // of both pointers are equal.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign pop   = !empty && bus.out_ready &&
                   ((state_q == S_COLLECT) || (state_q == S_DRAIN));
    assign match = (state_q == S_COLLECT) && bus.en && bus.flag;
    // A full FIFO still accepts a push when a pop frees the head slot.
    assign push  = match && (!full || pop);
    assign drop  = match && full && !pop;

    assign count_upd    = !match               ? count_q :
                          (count_q == COUNT_MAX) ? count_q :
                          count_q + MEM_WIDTH'(1);
    assign overflow_upd = overflow_q | drop;

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the case statement leaves a value unassigned, which
        // would otherwise infer a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + (PTR_W + 1)'(push);
        rd_ptr_d   = rd_ptr_q + (PTR_W + 1)'(pop);
        count_d    = count_upd;
        overflow_d = overflow_upd;
        seen_low_d = 1'b0;
        arm        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    arm     = 1'b1;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.fin) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Re-arm needs start low at some edge in DONE and then high,
                // so a start level held across the whole run does not loop.
                if (bus.start && seen_low_q) begin
                    arm     = 1'b1;
                    state_d = S_COLLECT;
                end else begin
                    seen_low_d = seen_low_q | !bus.start;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (arm) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others regardless of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            seen_low_q <= seen_low_d;
        end
    end

    // NOTE: the storage array is reset because out_addr reads it directly and
    // must be 0 after reset; it is only DEPTH small words, so this is cheap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.addr;
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_addr  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.done      = (state_q == S_DONE);

`ifdef PTM_COLLECT_CHECK_EN
    logic mismatch_q, mismatch_d;

    // Compared on the fin edge using the count and overflow that include any
    // match sampled on that same edge.
    always_comb begin
        mismatch_d = mismatch_q;
        if (arm) begin
            mismatch_d = 1'b0;
        end else if ((state_q == S_COLLECT) && bus.fin) begin
            mismatch_d = (count_upd != bus.result) ||
                         (overflow_upd && (count_upd == COUNT_MAX));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.mismatch = mismatch_q;
`else
    logic unused_result;

    assign unused_result = ^bus.result;
    assign bus.mismatch  = 1'b0;
`endif

endmodule
